seq_multiplier: RTL and testbench



---
 rtl/seq_multiplier_if.sv | 24 ++
 rtl/seq_multiplier.sv | 151 +++++++++++++++
 tb/tb_seq_multiplier.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_multiplier_if.sv
// Operand/result handshake bundle for the iterative multiplier.
interface seq_multiplier_if #(
    parameter int unsigned WIDTH = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic                   signed_mode;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     product;
    logic                   busy;

    modport master (
        output in_valid, signed_mode, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, signed_mode, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add WIDTH x WIDTH multiplier, unsigned or two's complement,
// one partial product per clock, valid/ready on both sides.
module seq_multiplier #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    seq_multiplier_if.slave  bus
);
    localparam int unsigned PW = 2 * WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg;
    logic [PW-1:0]    r_product;
    logic             r_out_valid;
    logic             r_in_ready;
    logic             r_busy;

    logic [1:0]       w_state;
    logic [WIDTH-1:0] w_mcand;
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;
    logic [CNT_W-1:0] w_cnt;
    logic             w_neg;
    logic [PW-1:0]    w_product;
    logic             w_out_valid;
    logic             w_in_ready;
    logic             w_busy;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_shift_hi;
    logic [WIDTH-1:0] w_shift_lo;
    logic [PW-1:0]    w_acc;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;

    // One shift-add step: the low half of the accumulator doubles as the multiplier.
    always_comb begin
        w_sum      = (WIDTH+1)'({1'b0, r_hi})
                   + (r_lo[0] ? (WIDTH+1)'({1'b0, r_mcand}) : (WIDTH+1)'(0));
        w_shift_hi = w_sum[WIDTH:1];
        w_shift_lo = {w_sum[0], r_lo[WIDTH-1:1]};
        w_acc      = {w_shift_hi, w_shift_lo};
        w_cnt_inc  = r_cnt + CNT_W'(1);
        // Magnitudes; the most-negative value negates to itself, which reads as 2^(WIDTH-1) unsigned.
        w_mag_a    = (bus.signed_mode && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
        w_mag_b    = (bus.signed_mode && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;
    end

    // Next-state and next-output decode.
    always_comb begin
        w_state     = r_state;
        w_mcand     = r_mcand;
        w_hi        = r_hi;
        w_lo        = r_lo;
        w_cnt       = r_cnt;
        w_neg       = r_neg;
        w_product   = r_product;
        w_out_valid = r_out_valid;
        w_in_ready  = r_in_ready;
        w_busy      = r_busy;

        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_mcand    = w_mag_a;
                    w_lo       = w_mag_b;
                    w_hi       = '0;
                    w_cnt      = '0;
                    w_neg      = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    w_in_ready = 1'b0;
                    w_busy     = 1'b1;
                    w_state    = S_RUN;
                end
            end
            S_RUN: begin
                w_hi  = w_shift_hi;
                w_lo  = w_shift_lo;
                w_cnt = w_cnt_inc;
                if (w_cnt_inc == CNT_W'(WIDTH)) begin
                    w_product   = r_neg ? (~w_acc + PW'(1)) : w_acc;
                    w_out_valid = 1'b1;
                    w_state     = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_out_valid = 1'b0;
                    w_in_ready  = 1'b1;
                    w_busy      = 1'b0;
                    w_state     = S_IDLE;
                end
            end
            default: begin
                w_out_valid = 1'b0;
                w_in_ready  = 1'b1;
                w_busy      = 1'b0;
                w_state     = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state;
        end
    end

    // Datapath and registered outputs; reset discards any in-flight product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand     <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_cnt       <= '0;
            r_neg       <= 1'b0;
            r_product   <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_mcand     <= w_mcand;
            r_hi        <= w_hi;
            r_lo        <= w_lo;
            r_cnt       <= w_cnt;
            r_neg       <= w_neg;
            r_product   <= w_product;
            r_out_valid <= w_out_valid;
            r_in_ready  <= w_in_ready;
            r_busy      <= w_busy;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.product   = r_product;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier at WIDTH=4 and WIDTH=8.
module tb_seq_multiplier;
    localparam int unsigned W4 = 4;
    localparam int unsigned W8 = 8;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc   = 0;
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          rnd_or   = 1'b0;
    logic [15:0] q4[$];
    logic [15:0] q8[$];

    always #5 clk = ~clk;

    // Count rising edges so latencies can be measured in cycles.
    always @(posedge clk) cyc <= cyc + 1;

    seq_multiplier_if #(.WIDTH(W4)) b4();
    seq_multiplier_if #(.WIDTH(W8)) b8();

    seq_multiplier #(.WIDTH(W4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    seq_multiplier #(.WIDTH(W8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_mul(input int w, input logic [7:0] a, input logic [7:0] b,
                                            input logic sm);
        longint av, bv, p;
        av = longint'(a);
        bv = longint'(b);
        if (sm && a[w-1]) av = av - (longint'(1) << w);
        if (sm && b[w-1]) bv = bv - (longint'(1) << w);
        p = av * bv;
        return 16'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    function automatic logic rdy(input bit w8);
        return w8 ? b8.in_ready : b4.in_ready;
    endfunction

    function automatic logic ovld(input bit w8);
        return w8 ? b8.out_valid : b4.out_valid;
    endfunction

    // Present one operand set, hold it until accepted, optionally log the expected product.
    task automatic issue(input bit w8, input logic [7:0] a, input logic [7:0] b, input logic sm,
                         input bit push, input logic [15:0] exp, output int unsigned t_acc);
        int k = 0;
        @(posedge clk);
        #1;
        if (w8) begin
            b8.a = a; b8.b = b; b8.signed_mode = sm; b8.in_valid = 1'b1;
        end else begin
            b4.a = a[3:0]; b4.b = b[3:0]; b4.signed_mode = sm; b4.in_valid = 1'b1;
        end
        while (!rdy(w8) && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!rdy(w8)) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready got 0, expected 1 within 300 cycles");
            b4.in_valid = 1'b0;
            b8.in_valid = 1'b0;
            t_acc = 0;
            return;
        end
        @(posedge clk);
        #1;
        t_acc = cyc;
        if (w8) b8.in_valid = 1'b0;
        else    b4.in_valid = 1'b0;
        if (push) begin
            if (w8) q8.push_back(exp);
            else    q4.push_back(exp);
        end
    endtask

    task automatic wait_valid(input bit w8, output int unsigned t_v);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ovld(w8) && k < 100);
        if (!ovld(w8)) begin
            n_checks++;
            n_fail++;
            $display("FAIL valid_timeout: out_valid got 0, expected 1 within 100 cycles");
        end
        t_v = cyc;
    endtask

    initial begin
        int unsigned t0, t1, tv;
        logic [7:0]  ra, rb;
        logic        rs;
        bit          sel;
        int          k;

        b4.in_valid = 1'b0; b4.signed_mode = 1'b0; b4.a = '0; b4.b = '0; b4.out_ready = 1'b0;
        b8.in_valid = 1'b0; b8.signed_mode = 1'b0; b8.a = '0; b8.b = '0; b8.out_ready = 1'b0;

        #12;
        check("rst_in_ready",  b4.in_ready,  1);
        check("rst_out_valid", b4.out_valid, 0);
        check("rst_busy",      b4.busy,      0);
        check("rst_product",   b4.product,   0);
        check("rst_product8",  b8.product,   0);
        #5 rst_n = 1'b1;

        fork
            // Scoreboard monitors: compare whenever a product is consumed.
            forever begin
                @(negedge clk);
                if (rst_n && b4.out_valid && b4.out_ready) begin
                    if (q4.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL w4_extra_result: got 0x%0h with no expected entry", b4.product);
                    end else begin
                        check("w4_product", longint'(b4.product), longint'(q4.pop_front()));
                    end
                end
            end
            forever begin
                @(negedge clk);
                if (rst_n && b8.out_valid && b8.out_ready) begin
                    if (q8.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL w8_extra_result: got 0x%0h with no expected entry", b8.product);
                    end else begin
                        check("w8_product", longint'(b8.product), longint'(q8.pop_front()));
                    end
                end
            end
            // Random backpressure while the random phase runs.
            forever begin
                @(posedge clk);
                #1;
                if (rnd_or) begin
                    b4.out_ready = 1'($urandom_range(0, 1));
                    b8.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none

        // Unsigned 15*15 with latency and in_ready/busy tracking.
        issue(0, 8'd15, 8'd15, 1'b0, 1'b1, 16'h00E1, t0);
        check("run_in_ready", b4.in_ready, 0);
        check("run_busy",     b4.busy,     1);
        wait_valid(0, tv);
        check("latency_15x15", tv - t0, W4);
        check("done_in_ready", b4.in_ready, 0);

        // Backpressure: result held, new operand pulses ignored.
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            b4.in_valid = i[0];
            b4.a = 4'd3; b4.b = 4'd3;
            @(negedge clk);
            check("hold_valid",   b4.out_valid, 1);
            check("hold_product", b4.product,   8'hE1);
            check("hold_ready",   b4.in_ready,  0);
            @(posedge clk);
            #1;
        end
        b4.in_valid  = 1'b0;
        b4.out_ready = 1'b1;
        @(posedge clk);
        #1;
        b4.out_ready = 1'b0;
        check("consume_valid",   b4.out_valid, 0);
        check("consume_ready",   b4.in_ready,  1);
        check("consume_busy",    b4.busy,      0);
        check("consume_product", b4.product,   8'hE1);

        // Signed directed vectors; last one leaves a nonzero product for the reset test.
        b4.out_ready = 1'b1;
        issue(0, 8'h08, 8'h08, 1'b1, 1'b1, 16'h0040, t0);
        issue(0, 8'h00, 8'h09, 1'b1, 1'b1, 16'h0000, t0);
        issue(0, 8'h0D, 8'h05, 1'b1, 1'b1, 16'h00F1, t0);
        wait_valid(0, tv);
        check("signed_latency", tv - t0, W4);
        @(posedge clk);
        #1;

        // Asynchronous reset two cycles into a run discards it.
        issue(0, 8'd9, 8'd9, 1'b0, 1'b0, 16'h0000, t0);
        @(posedge clk);
        @(posedge clk);
        #3;
        check("pre_rst_busy", b4.busy, 1);
        rst_n = 1'b0;
        #1;
        check("arst_in_ready",  b4.in_ready,  1);
        check("arst_out_valid", b4.out_valid, 0);
        check("arst_busy",      b4.busy,      0);
        check("arst_product",   b4.product,   0);
        #2 rst_n = 1'b1;
        issue(0, 8'd6, 8'd7, 1'b0, 1'b1, 16'd42, t0);
        wait_valid(0, tv);
        check("post_rst_latency", tv - t0, W4);

        // Back-to-back at WIDTH=8: WIDTH RUN edges, one DONE edge, one IDLE edge between accepts.
        b8.out_ready = 1'b1;
        issue(1, 8'hFF, 8'hFF, 1'b0, 1'b1, 16'hFE01, t0);
        issue(1, 8'h80, 8'h7F, 1'b1, 1'b1, 16'hC080, t1);
        check("b2b_spacing", t1 - t0, W8 + 2);
        wait_valid(1, tv);
        check("b2b_latency", tv - t1, W8);

        // Random operands and modes on both widths with input idles and output stalls.
        rnd_or = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            sel = i[0];
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rs  = 1'($urandom_range(0, 1));
            if (!sel) begin
                ra[7:4] = 4'h0;
                rb[7:4] = 4'h0;
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            issue(sel, ra, rb, rs, 1'b1, ref_mul(sel ? 8 : 4, ra, rb, rs), t0);
        end
        rnd_or = 1'b0;
        @(posedge clk);
        #2;
        b4.out_ready = 1'b1;
        b8.out_ready = 1'b1;
        k = 0;
        while ((q4.size() != 0 || q8.size() != 0) && k < 200) begin
            @(posedge clk);
            k++;
        end
        repeat (3) @(posedge clk);
        check("w4_results_outstanding", q4.size(), 0);
        check("w8_results_outstanding", q8.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
